// File: rtl/cle_key_reader.sv
// Host-side sequencer for the CLE serial-readout GAL: unlock-key accesses, then NBITS serial data reads.
// Optional: define CLE_PARITY_EN to append an odd-parity access and report parity_err.
module cle_key_reader #(
  parameter int NBITS      = 16,
  parameter int KEY_LEN    = 4,
  parameter int STROBE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*KEY_LEN-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic [NBITS-1:0]     data_out,
  output logic                 parity_err,
  output logic                 SSER,
  output logic                 BA13,
  output logic                 BA12,
  output logic [3:0]           BA_NIB,
  output logic                 BR_W,
  input  logic                 SDRD
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

`ifdef CLE_PARITY_EN
  localparam int DATA_ACC = NBITS + 1;
`else
  localparam int DATA_ACC = NBITS;
`endif

  logic [2:0]           state;
  logic                 data_ph;   // 0 = key phase, 1 = data phase
  logic [5:0]           idx;
  logic [2:0]           stb_cnt;
  logic [4*KEY_LEN-1:0] key_q;     // shifts right so the current nibble is always [3:0]
  logic [NBITS-1:0]     data_shift;
  logic                 in_access;

  assign data_shift = (data_out << 1) | NBITS'(SDRD);
  assign in_access  = (state == S_SETUP) || (state == S_STROBE) || (state == S_GAP);

  // NOTE: bus outputs are decoded from the state register rather than registered, so the
  // asynchronous reset releases SSER/BA12 in the same cycle without a separate reset path.
  assign SSER   = (state != S_STROBE);
  assign BA13   = 1'b0;
  assign BA12   = in_access;
  assign BA_NIB = (in_access && !data_ph) ? key_q[3:0] : 4'h0;
  assign BR_W   = 1'b1;
  assign busy   = in_access;
  assign done   = (state == S_FINISH);

`ifdef CLE_PARITY_EN
  logic par_bit;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register in this
  // block sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      data_ph  <= 1'b0;
      idx      <= '0;
      stb_cnt  <= '0;
      key_q    <= '0;
      data_out <= '0;
`ifdef CLE_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_q    <= key;
            data_out <= '0;
            data_ph  <= 1'b0;
            idx      <= '0;
            stb_cnt  <= '0;
            state    <= S_SETUP;
`ifdef CLE_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          stb_cnt <= '0;
          state   <= S_STROBE;
        end
        S_STROBE: begin
          if (stb_cnt == 3'(STROBE_CYC - 1)) begin
            if (data_ph) begin
`ifdef CLE_PARITY_EN
              if (idx == 6'(NBITS)) par_bit <= SDRD;
              else                  data_out <= data_shift;
`else
              data_out <= data_shift;
`endif
            end
            state <= S_GAP;
          end else begin
            stb_cnt <= stb_cnt + 3'd1;
          end
        end
        S_GAP: begin
          if (!data_ph) begin
            key_q <= key_q >> 4;
            if (idx == 6'(KEY_LEN - 1)) begin
              data_ph <= 1'b1;
              idx     <= '0;
            end else begin
              idx <= idx + 6'd1;
            end
            state <= S_SETUP;
          end else if (idx == 6'(DATA_ACC - 1)) begin
            state <= S_FINISH;
          end else begin
            idx   <= idx + 6'd1;
            state <= S_SETUP;
          end
        end
        S_FINISH: begin
`ifdef CLE_PARITY_EN
          parity_err <= ~((^data_out) ^ par_bit);
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef CLE_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cle_key_reader.sv
// Directed self-checking bench for cle_key_reader: reset, key order, data assembly, busy-start, mid-run reset.
module tb_cle_key_reader;
  localparam int NBITS      = 16;
  localparam int KEY_LEN    = 4;
  localparam int STROBE_CYC = 2;
`ifdef CLE_PARITY_EN
  localparam int ACCESSES = KEY_LEN + NBITS + 1;
`else
  localparam int ACCESSES = KEY_LEN + NBITS;
`endif
  localparam int LATENCY = 1 + ACCESSES * (STROBE_CYC + 2);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [4*KEY_LEN-1:0] key;
  logic                 busy, done, parity_err;
  logic [NBITS-1:0]     data_out;
  logic                 SSER, BA13, BA12, BR_W, SDRD;
  logic [3:0]           BA_NIB;

  cle_key_reader #(.NBITS(NBITS), .KEY_LEN(KEY_LEN), .STROBE_CYC(STROBE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy), .done(done),
    .data_out(data_out), .parity_err(parity_err), .SSER(SSER), .BA13(BA13), .BA12(BA12),
    .BA_NIB(BA_NIB), .BR_W(BR_W), .SDRD(SDRD)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor / CLE model: feeds SDRD per access and records protocol violations.
  logic [15:0] pat_q;
  logic        par_q;
  logic [3:0]  nib_log [KEY_LEN];
  logic        prev_sser = 1'b1;
  int acc, low_len, hi_len, bad_len, bad_gap, bad_addr, bad_brw, bad_busy;

  always @(negedge clk) begin
    if (BR_W !== 1'b1) bad_brw++;
    if (!rst_n) begin
      acc = 0; low_len = 0; hi_len = 0;
    end else if (SSER === 1'b0) begin
      if (prev_sser) begin
        if (hi_len != ((acc == 0) ? 1 : 2)) bad_gap++;
        hi_len = 0;
        if (BA12 !== 1'b1 || BA13 !== 1'b0) bad_addr++;
        if (acc < KEY_LEN) nib_log[acc] = BA_NIB;
        else if (BA_NIB !== 4'h0) bad_addr++;
        if (acc >= KEY_LEN) SDRD = (acc - KEY_LEN < 16) ? pat_q[15 - (acc - KEY_LEN)] : par_q;
        acc++;
      end
      low_len++;
    end else begin
      if (!prev_sser) begin
        if (low_len != STROBE_CYC) bad_len++;
        low_len = 0;
      end
      if (BA12 === 1'b1) hi_len++;
    end
    prev_sser = SSER;
  end

  task automatic run_seq(input logic [15:0] k, input logic [15:0] pat, input logic pbit,
                         input int poke_at, output int lat);
    int n;
    key = k; pat_q = pat; par_q = pbit;
    acc = 0; hi_len = 0; low_len = 0;
    bad_len = 0; bad_gap = 0; bad_addr = 0; bad_brw = 0; bad_busy = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    lat = -1;
    while (n <= LATENCY + 20) begin
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) bad_busy++;
      start = (n == poke_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  int lat;
  int seen_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; key = '0; SDRD = 1'b0; pat_q = '0; par_q = 1'b0;
    acc = 0; bad_len = 0; bad_gap = 0; bad_addr = 0; bad_brw = 0; bad_busy = 0;
    repeat (3) @(negedge clk);
    check("rst_sser",   SSER, 1);
    check("rst_ba12",   BA12, 0);
    check("rst_ba13",   BA13, 0);
    check("rst_ba_nib", BA_NIB, 0);
    check("rst_br_w",   BR_W, 1);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_data",   data_out, 0);
    check("rst_perr",   parity_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Key order and BEEF assembly
    run_seq(16'hA5C3, 16'hBEEF, ~^16'hBEEF, 0, lat);
    check("a_latency",  lat, LATENCY);
    check("a_data",     data_out, 16'hBEEF);
    check("a_busy_low", busy, 0);
    check("a_perr",     parity_err, 0);
    check("a_nib0",     nib_log[0], 4'h3);
    check("a_nib1",     nib_log[1], 4'hC);
    check("a_nib2",     nib_log[2], 4'h5);
    check("a_nib3",     nib_log[3], 4'hA);
    check("a_accesses", acc, ACCESSES);
    check("a_strobe_len", bad_len, 0);
    check("a_setup_gap",  bad_gap, 0);
    check("a_addr",       bad_addr, 0);
    check("a_br_w",       bad_brw, 0);
    check("a_busy_hold",  bad_busy, 0);
    @(negedge clk);
    check("a_done_pulse", done, 0);
    check("a_data_hold",  data_out, 16'hBEEF);
    check("a_ba12_idle",  BA12, 0);

    // Start re-asserted while busy at cycle 20
    run_seq(16'h1234, 16'h8001, ~^16'h8001, 20, lat);
    check("b_latency",  lat, LATENCY);
    check("b_data",     data_out, 16'h8001);
    check("b_nib0",     nib_log[0], 4'h4);
    check("b_nib3",     nib_log[3], 4'h1);
    check("b_accesses", acc, ACCESSES);
    repeat (LATENCY + 5) @(negedge clk);
    check("b_no_restart", busy, 0);

    // Reset mid-sequence during a data strobe
    key = 16'h0F0F; pat_q = 16'hFFFF; par_q = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (38) @(negedge clk);
    check("r_sser_low", SSER, 0);
    #1 rst_n = 1'b0;
    #1;
    check("r_sser_async", SSER, 1);
    check("r_ba12_async", BA12, 0);
    check("r_busy_async", busy, 0);
    seen_done = 0;
    repeat (3) @(negedge clk) if (done) seen_done++;
    rst_n = 1'b1;
    repeat (LATENCY) @(negedge clk) if (done) seen_done++;
    check("r_no_done", seen_done, 0);
    check("r_data_cleared", data_out, 0);

    // Fresh start after reset
    run_seq(16'h0F0F, 16'h5A3C, ~^16'h5A3C, 0, lat);
    check("c_latency", lat, LATENCY);
    check("c_data",    data_out, 16'h5A3C);
    check("c_nib0",    nib_log[0], 4'hF);
    check("c_nib1",    nib_log[1], 4'h0);
    check("c_strobe_len", bad_len, 0);

`ifdef CLE_PARITY_EN
    @(negedge clk);
    run_seq(16'hA5C3, 16'h0001, 1'b0, 0, lat);
    check("p0_latency", lat, 85);
    check("p0_data",    data_out, 16'h0001);
    check("p0_perr",    parity_err, 0);
    @(negedge clk);
    run_seq(16'hA5C3, 16'h0001, 1'b1, 0, lat);
    check("p1_data",    data_out, 16'h0001);
    check("p1_perr",    parity_err, 1);
    @(negedge clk);
    check("p1_perr_hold", parity_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
